// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage plus IF/ID pipeline register.
// Issues one 32-bit instruction read at a time over a req/gnt/rvalid
// handshake. A one-entry hold buffer catches a response that arrives while
// Decode is stalled. Execute redirects squash the in-flight response.
// Optional feature macro: FETCH_PERF_CNT_EN adds the InstrCount_F and
// StallCount_F performance counters.
module fetch_stage #(
  parameter int               XLEN      = 64,
  parameter logic [XLEN-1:0]  RESET_PC  = {XLEN{1'b0}},
  parameter logic [31:0]      NOP_INSTR = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Stall_F,
  input  logic             Stall_D,
  input  logic             Flush_D,
  input  logic             PCSrc_E,
  input  logic [XLEN-1:0]  PCTarget_E,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      Instr_D,
  output logic [XLEN-1:0]  PC_D,
  output logic [XLEN-1:0]  PCPlus4_D,
  output logic             Valid_D
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [63:0]      InstrCount_F,
  output logic [63:0]      StallCount_F
`endif
);

  localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_e;

  fetch_state_e    state_r;
  fetch_state_e    state_nxt_s;
  logic [XLEN-1:0] pc_f_r;
  logic [XLEN-1:0] pc_out_r;
  logic            buf_valid_r;
  logic [31:0]     buf_instr_r;
  logic [XLEN-1:0] buf_pc_r;
  logic            valid_d_r;
  logic [31:0]     instr_d_r;
  logic [XLEN-1:0] pc_d_r;
  logic [XLEN-1:0] pcplus4_d_r;

  logic            rsp_take_s;
  logic            rsp_to_ifid_s;
  logic            rsp_to_buf_s;
  logic            drain_buf_s;
  logic            req_s;
  logic            gnt_s;
  logic            load_s;
  logic [31:0]     load_instr_s;
  logic [XLEN-1:0] load_pc_s;
  logic [XLEN-1:0] target_s;
  logic            unused_tgt_s;

  // Redirect target is word aligned; the low two bits carry no information.
  assign target_s     = {PCTarget_E[XLEN-1:2], 2'b00};
  assign unused_tgt_s = ^PCTarget_E[1:0];

  // Classify the current response and decide whether a new request goes out.
  always_comb begin
    rsp_take_s    = imem_rvalid && (state_r == S_WAIT) && !PCSrc_E;
    rsp_to_ifid_s = rsp_take_s && !Stall_D;
    rsp_to_buf_s  = rsp_take_s && Stall_D;
    drain_buf_s   = buf_valid_r && !Stall_D && !PCSrc_E;
    if (rst) begin
      req_s = 1'b0;
    end else begin
      req_s = ((state_r == S_REQ) || ((state_r == S_WAIT) && rsp_to_ifid_s))
              && !Stall_F && !buf_valid_r && !PCSrc_E;
    end
    gnt_s = req_s && imem_gnt;
  end

  assign imem_req  = req_s;
  assign imem_addr = pc_f_r;

  // Select what IF/ID loads this cycle: the hold buffer is older, so it wins.
  always_comb begin
    load_s       = 1'b0;
    load_instr_s = NOP_INSTR;
    load_pc_s    = pc_out_r;
    if (drain_buf_s) begin
      load_s       = 1'b1;
      load_instr_s = buf_instr_r;
      load_pc_s    = buf_pc_r;
    end else if (rsp_to_ifid_s) begin
      load_s       = 1'b1;
      load_instr_s = imem_rdata;
      load_pc_s    = pc_out_r;
    end else begin
      load_s       = 1'b0;
    end
  end

  // Next-state logic for the request/response tracker.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_REQ: begin
        if (PCSrc_E) begin
          state_nxt_s = S_REQ;
        end else if (gnt_s) begin
          state_nxt_s = S_WAIT;
        end else begin
          state_nxt_s = S_REQ;
        end
      end
      S_WAIT: begin
        if (PCSrc_E) begin
          state_nxt_s = imem_rvalid ? S_REQ : S_DRAIN;
        end else if (imem_rvalid) begin
          state_nxt_s = gnt_s ? S_WAIT : S_REQ;
        end else begin
          state_nxt_s = S_WAIT;
        end
      end
      S_DRAIN: begin
        if (imem_rvalid) begin
          state_nxt_s = S_REQ;
        end else begin
          state_nxt_s = S_DRAIN;
        end
      end
      default: state_nxt_s = S_REQ;
    endcase
  end

  // State register, fetch PC and the PC of the outstanding request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= S_REQ;
      pc_f_r   <= RESET_PC;
      pc_out_r <= RESET_PC;
    end else begin
      state_r <= state_nxt_s;
      if (PCSrc_E) begin
        pc_f_r <= target_s;
      end else if (gnt_s) begin
        pc_f_r <= pc_f_r + PC_STEP;
      end else begin
        pc_f_r <= pc_f_r;
      end
      if (gnt_s) begin
        pc_out_r <= pc_f_r;
      end else begin
        pc_out_r <= pc_out_r;
      end
    end
  end

  // Hold buffer: catches a response while Decode is stalled, empties on release.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid_r <= 1'b0;
      buf_instr_r <= NOP_INSTR;
      buf_pc_r    <= {XLEN{1'b0}};
    end else if (PCSrc_E) begin
      buf_valid_r <= 1'b0;
    end else if (rsp_to_buf_s) begin
      buf_valid_r <= 1'b1;
      buf_instr_r <= imem_rdata;
      buf_pc_r    <= pc_out_r;
    end else if (drain_buf_s) begin
      buf_valid_r <= 1'b0;
    end else begin
      buf_valid_r <= buf_valid_r;
    end
  end

  // IF/ID register: flush beats stall, stall beats load, otherwise a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_d_r   <= 1'b0;
      instr_d_r   <= NOP_INSTR;
      pc_d_r      <= {XLEN{1'b0}};
      pcplus4_d_r <= {XLEN{1'b0}};
    end else if (Flush_D) begin
      valid_d_r <= 1'b0;
      instr_d_r <= NOP_INSTR;
    end else if (Stall_D) begin
      valid_d_r <= valid_d_r;
    end else if (load_s) begin
      valid_d_r   <= 1'b1;
      instr_d_r   <= load_instr_s;
      pc_d_r      <= load_pc_s;
      pcplus4_d_r <= load_pc_s + PC_STEP;
    end else begin
      valid_d_r <= 1'b0;
      instr_d_r <= NOP_INSTR;
    end
  end

  assign Valid_D   = valid_d_r;
  assign Instr_D   = instr_d_r;
  assign PC_D      = pc_d_r;
  assign PCPlus4_D = pcplus4_d_r;

`ifdef FETCH_PERF_CNT_EN
  logic [63:0] instr_cnt_r;
  logic [63:0] stall_cnt_r;

  // Count valid IF/ID loads and cycles with any fetch/decode stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_cnt_r <= 64'd0;
      stall_cnt_r <= 64'd0;
    end else begin
      if (load_s && !Flush_D) begin
        instr_cnt_r <= instr_cnt_r + 64'd1;
      end else begin
        instr_cnt_r <= instr_cnt_r;
      end
      if (Stall_F || Stall_D) begin
        stall_cnt_r <= stall_cnt_r + 64'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  assign InstrCount_F = instr_cnt_r;
  assign StallCount_F = stall_cnt_r;
`endif

endmodule
